priority_encoder_pipe: RTL
==========================

PRIORITY_ENCODER_PIPE -- requirements
Module: priority_encoder_pipe

Interface
REQ-001 The block SHALL have parameter `WIDTH`, default 8, giving the number of request lines (power of two, 2..64).
REQ-002 The block SHALL have parameter `IDX_W`, default 3, giving the index width; `IDX_W` SHALL equal log2(`WIDTH`).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; all other ports are synchronous to `clk`.
REQ-004 Port `clk`: input, 1 bit, single clock, rising edge.
REQ-005 Port `rst_n`: input, 1 bit, asynchronous reset, active low.
REQ-006 Port `req`: input, `WIDTH` bits, request vector; bit i set means request i is asserted.
REQ-007 Port `in_valid`: input, 1 bit, `req` is valid this cycle.
REQ-008 Port `in_ready`: output, 1 bit, block accepts `req` this cycle.
REQ-009 Port `out_idx`: output, `IDX_W` bits, encoded index of the winning request.
REQ-010 Port `out_any`: output, 1 bit, at least one request bit was set in the captured vector.
REQ-011 Port `out_valid`: output, 1 bit, `out_idx` and `out_any` hold a result.
REQ-012 Port `out_ready`: input, 1 bit, downstream consumes the result this cycle.

Function
REQ-013 The block SHALL have a single output register stage with two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
REQ-014 `in_ready` SHALL be combinational and equal !`out_valid` || `out_ready`.
REQ-015 An accept SHALL occur on a rising edge where `in_valid` && `in_ready`; the result SHALL appear on the next cycle (latency 1).
REQ-016 On accept, `out_valid` SHALL go to 1, and `out_any` SHALL be loaded with the OR of all bits of `req`.
REQ-017 In fixed-priority mode, `out_idx` SHALL be loaded with the index of the highest-numbered set bit of `req` (MSB wins).
REQ-018 If `req` is all zero on accept, `out_any`=0, `out_idx`=0 and `out_valid`=1; the result is still delivered.
REQ-019 While FULL and `out_ready`=0, `out_idx` and `out_any` SHALL hold stable, and `in_valid` SHALL be ignored.
REQ-020 In FULL with `out_ready`=1 and `in_valid`=1, the register SHALL load the new result and `out_valid` SHALL stay 1.
REQ-021 The block SHALL sustain one result per cycle.
REQ-022 In FULL with `out_ready`=1 and `in_valid`=0, the block SHALL go to EMPTY.
REQ-023 Outputs in EMPTY SHALL retain their last values; they are don't-care to the consumer.
REQ-024 No combinational path SHALL exist from `req` or `in_valid` to any output other than `in_ready`.

Reset
REQ-025 While `rst_n`=0, the block SHALL asynchronously force `out_valid`=0, `out_idx`=0, `out_any`=0 and round-robin pointer `ptr`=`WIDTH`-1.
REQ-026 Reset asserted mid-transfer SHALL discard the held result.
REQ-027 `in_ready` SHALL read 1 during reset.
REQ-028 Reset deassertion is synchronised externally; the first accept may occur on the first rising edge after deassertion.

Configuration
REQ-029 With macro `PRIORITY_ENCODER_RR_EN` defined, the block SHALL use round-robin priority via register `ptr` (`IDX_W` bits).
REQ-030 In round-robin mode, the search SHALL start at index `ptr` and descend, wrapping from 0 to `WIDTH`-1; the first set bit wins.
REQ-031 In round-robin mode, on an accept with `out_any`=1 and winner g, `ptr` SHALL be loaded with (g-1) mod `WIDTH`.
REQ-032 In round-robin mode, `ptr` SHALL be unchanged on an accept with all-zero `req` or when no accept occurs.
REQ-033 Without `PRIORITY_ENCODER_RR_EN`, `ptr` SHALL not exist and the block SHALL use the fixed MSB priority of REQ-017.
REQ-034 With `PRIORITY_ENCODER_RR_EN`, the first accept after reset SHALL give the same result as fixed priority.

Verification (`WIDTH`=8)
REQ-035 Basic encode: `req`=8'b0001_0110, `in_valid`=1, `out_ready`=1 -> next cycle `out_valid`=1, `out_idx`=4, `out_any`=1.
REQ-036 All-zero request: `req`=8'h00 accepted -> `out_valid`=1, `out_any`=0, `out_idx`=0.
REQ-037 Backpressure: result idx 7 held with `out_ready`=0 for 3 cycles while `req`=8'h01 is presented -> `in_ready`=0, `out_idx` stays 7; after `out_ready`=1 -> next result idx 0.
REQ-038 Streaming: `in_valid`=`out_ready`=1 for 4 cycles with `req`=8'h80, 8'h40, 8'h20, 8'h10 -> `out_idx`=7, 6, 5, 4 on consecutive cycles with no bubble.
REQ-039 Round-robin (macro defined): `req`=8'hFF x3 -> `out_idx`=7, 6, 5; then `req`=8'h81 -> `out_idx`=0, `ptr`=7.
REQ-040 Mid-operation reset: `rst_n`=0 while FULL -> `out_valid`=0, `out_idx`=0 and `in_ready`=1 immediately without a clock edge; RR `ptr`=7.

Source files
------------

// File: rtl/priority_encoder_pipe.sv
// Purpose: priority encoder with one registered result stage; MSB-wins, or round-robin when PRIORITY_ENCODER_RR_EN is defined.
// Latency: 1 cycle from accept to out_valid; sustains one result per cycle.
// Backpressure: in_ready = !out_valid || out_ready; a held result stays stable until consumed.
module priority_encoder_pipe #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_any,
  output logic             out_valid,
  input  logic             out_ready
);

  // Reject configurations where the index width cannot address every request line.
  if (IDX_W != $clog2(WIDTH) || WIDTH < 2 || WIDTH > 64) begin : g_bad_cfg
    $error("priority_encoder_pipe: IDX_W must equal log2(WIDTH), WIDTH in 2..64");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             accept;

  assign in_ready  = (state == EMPTY) || out_ready;
  assign out_valid = (state == FULL);
  assign accept    = in_valid && in_ready;
  assign win_any   = |req;

`ifdef PRIORITY_ENCODER_RR_EN
  // Round-robin pointer: index where the next search begins (descending).
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk downward from ptr with natural wrap; first set bit wins.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      cand = ptr - IDX_W'(k);
      if (!found && req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  // Move the pointer just below the winner so the winner gets lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDX_W'(WIDTH - 1);
    end else if (accept && win_any) begin
      ptr <= win_idx - IDX_W'(1);
    end
  end
`else
  // Fixed priority: later (higher) set bits overwrite earlier ones, so the MSB wins.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) begin
        win_idx = IDX_W'(i);
      end
    end
  end
`endif

  // Output stage: EMPTY/FULL state plus the result register; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      out_idx <= '0;
      out_any <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            out_idx <= win_idx;
            out_any <= win_any;
            state   <= FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (in_valid) begin
              out_idx <= win_idx;
              out_any <= win_any;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
